// File: rtl/reciprocal_unit_if.sv
// ============================================================================
// Module  : reciprocal_unit_if
// Brief   : Request/result handshake bundle for the reciprocal unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface reciprocal_unit_if #(
  parameter int DATA_W  = 18,
  parameter int RECIP_W = 36
);
  logic               i_valid;
  logic [DATA_W-1:0]  i_data;
  logic               o_ready;
  logic               o_valid;
  logic [RECIP_W-1:0] o_recip;
  logic               o_sat;

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_valid, o_recip, o_sat
  );

  modport master (
    output i_valid, i_data,
    input  o_ready, o_valid, o_recip, o_sat
  );
endinterface

`default_nettype wire

// File: rtl/reciprocal_unit.sv
// ============================================================================
// Module  : reciprocal_unit
// Brief   : Iterative Q0.RECIP_W reciprocal floor(2^RECIP_W / x), radix-2 restoring.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module reciprocal_unit #(
  parameter int DATA_W  = 18,
  parameter int RECIP_W = 36
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  reciprocal_unit_if.slave  io_bus
);

  localparam int              CNT_W  = $clog2(RECIP_W);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RECIP_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_div;
  logic [DATA_W:0]    r_rem;
  logic [RECIP_W-1:0] r_quot;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_spec;
  logic               r_ready;
  logic               r_valid;
  logic [RECIP_W-1:0] r_recip;
  logic               r_sat;

  logic [DATA_W+1:0]  w_rem_sh;
  logic               w_ge;
  logic [DATA_W:0]    w_diff;
  logic [DATA_W:0]    w_rem_nx;

  // The remainder never exceeds the divisor, so one extra bit on the
  // shifted value is enough for an exact compare.
  assign w_rem_sh = {r_rem, 1'b0};
  assign w_ge     = (w_rem_sh >= {2'b00, r_div});
  assign w_diff   = w_rem_sh[DATA_W:0] - {1'b0, r_div};
  assign w_rem_nx = w_ge ? w_diff : w_rem_sh[DATA_W:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_spec  <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_recip <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_valid) begin
            // Leading dividend bit is pre-loaded; the loop yields bits [RECIP_W-1:0].
            r_div   <= io_bus.i_data;
            r_rem   <= (DATA_W+1)'(1);
            r_quot  <= '0;
            r_cnt   <= '0;
            r_spec  <= (io_bus.i_data < DATA_W'(2));
            r_ready <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem_nx;
          r_quot <= {r_quot[RECIP_W-2:0], w_ge};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // x of 0 or 1 cannot be represented; clip but keep the fixed latency.
          r_recip <= r_spec ? '1 : r_quot;
          r_sat   <= r_spec;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.o_ready = r_ready;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_recip = r_recip;
  assign io_bus.o_sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_reciprocal_unit.sv
// ============================================================================
// Module  : tb_reciprocal_unit
// Brief   : Self-checking bench for reciprocal_unit against an integer 2^36/x model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reciprocal_unit;

  localparam int DATA_W  = 18;
  localparam int RECIP_W = 36;
  localparam int LAT     = RECIP_W + 1;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  reciprocal_unit_if #(.DATA_W(DATA_W), .RECIP_W(RECIP_W)) bus ();

  reciprocal_unit #(.DATA_W(DATA_W), .RECIP_W(RECIP_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running, limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_recip(input logic [63:0] x);
    if (x < 2) return (64'd1 << RECIP_W) - 64'd1;
    return (64'd1 << RECIP_W) / x;
  endfunction

  // Presents x in a cycle where the unit is idle; returns #1 after the accepting edge.
  task automatic start(input logic [DATA_W-1:0] x);
    @(negedge clk);
    check("ready_before_req", 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = x;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // Waits for the result of x; returns #1 after the o_valid edge.
  task automatic wait_done(input logic [DATA_W-1:0] x, input string tag, input bit noisy);
    int edges;
    bit got;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < LAT + 20) begin
      if (noisy) begin
        bus.i_valid = 1'($urandom_range(0, 1));
        bus.i_data  = DATA_W'($urandom);
      end
      @(posedge clk);
      edges++;
      #1;
      if (bus.o_valid) got = 1'b1;
      else if (noisy) check({tag, "_ready_low"}, 64'(bus.o_ready), 64'd0);
    end
    bus.i_valid = 1'b0;
    check({tag, "_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'(LAT));
    check({tag, "_recip"}, 64'(bus.o_recip), model_recip(64'(x)));
    check({tag, "_sat"}, 64'(bus.o_sat), 64'(x < 2));
  endtask

  initial begin
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] dir_vals [6];
    n_total     = 0;
    n_bad       = 0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_recip", 64'(bus.o_recip), 64'd0);
    check("rst_sat",   64'(bus.o_sat),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values, including both saturating cases and the largest divisor.
    dir_vals = '{18'd11, 18'd2, 18'd3, 18'd262143, 18'd1, 18'd0};
    foreach (dir_vals[i]) begin
      start(dir_vals[i]);
      wait_done(dir_vals[i], "dir", 1'b0);
    end
    check("const_11", 64'(model_recip(64'd11)), 64'd6247225157);

    // Single pulse, then the result holds.
    @(posedge clk);
    #1;
    check("pulse_single", 64'(bus.o_valid), 64'd0);
    check("hold_recip", 64'(bus.o_recip), 64'hFFFFFFFFF);
    check("hold_sat",   64'(bus.o_sat),   64'd1);

    // Requests while busy are ignored.
    start(18'd12345);
    wait_done(18'd12345, "busy", 1'b1);
    @(posedge clk);
    #1;
    check("busy_no_extra_valid", 64'(bus.o_valid), 64'd0);
    check("busy_ready_back", 64'(bus.o_ready), 64'd1);

    // Back-to-back: second request raised in the o_valid cycle.
    start(18'd1000);
    wait_done(18'd1000, "b2b_a", 1'b0);
    check("b2b_ready_in_valid", 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = 18'd777;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    check("b2b_accepted", 64'(bus.o_ready), 64'd0);
    wait_done(18'd777, "b2b_b", 1'b0);

    // Reset mid-division.
    start(18'd5);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.o_valid), 64'd0);
    check("abort_recip", 64'(bus.o_recip), 64'd0);
    check("abort_ready", 64'(bus.o_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 5; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", 64'(bus.o_valid), 64'd0);
    end
    start(18'd7);
    wait_done(18'd7, "after_abort", 1'b0);

    // Random divisors in [2, 2^18-1].
    for (int n = 0; n < 1000; n++) begin
      x = DATA_W'($urandom_range(2, (1 << DATA_W) - 1));
      start(x);
      wait_done(x, "rand", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
